out_capture: RTL and testbench

Downstream companion of the floating-point processor top: captures the integer result `io_out` whenever the processor strobes one of its output-port enables (`out_en`). Each captured result is tagged with its port index and queued in a small FIFO. The queue drains over a valid/ready stream to the host-side consumer. This decouples processor output bursts from a consumer that may stall.

---
 rtl/out_capture.sv | 109 ++++++++++
 tb/tb_out_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/out_capture.sv
// Captures strobed processor results, tagged with their port index, into a show-ahead FIFO drained by valid/ready.
// Optional build macro OUT_CAPTURE_TSTAMP_EN adds a 16-bit cycle timestamp per entry (m_tstamp).
module out_capture #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DW    = 23,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              io_out,
    input  logic [NCH-1:0]             out_en,
    output logic [DW-1:0]              m_data,
    output logic [CW-1:0]              m_ch,
`ifdef OUT_CAPTURE_TSTAMP_EN
    output logic [15:0]                m_tstamp,
`endif
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic                       multi,
    input  logic                       clr_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [DW-1:0] mem_data [DEPTH];
    logic [CW-1:0] mem_ch   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] low_idx;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          multi_evt;

`ifdef OUT_CAPTURE_TSTAMP_EN
    logic [15:0] mem_ts [DEPTH];
    logic [15:0] tcnt;
`endif

    // Lowest set strobe bit wins the tag.
    always_comb begin
        low_idx = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (out_en[i]) low_idx = CW'(i);
        end
    end

    assign push      = |out_en;
    assign multi_evt = (out_en & (out_en - NCH'(1))) != '0;
    assign full      = (level == LW'(DEPTH));
    assign pop       = m_valid & m_ready;
    assign push_ok   = push & (~full | pop);

    // Head presentation is a function of registered state only; zero while empty.
    assign m_valid = (level != '0);
    assign m_data  = m_valid ? mem_data[rd_ptr] : '0;
    assign m_ch    = m_valid ? mem_ch[rd_ptr]   : '0;
`ifdef OUT_CAPTURE_TSTAMP_EN
    assign m_tstamp = m_valid ? mem_ts[rd_ptr] : '0;
`endif

    // Control state: pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            multi  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && full && !pop) ovf <= 1'b1;
            else if (clr_err)         ovf <= 1'b0;
            if (multi_evt)            multi <= 1'b1;
            else if (clr_err)         multi <= 1'b0;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem_data[wr_ptr] <= io_out;
            mem_ch[wr_ptr]   <= low_idx;
`ifdef OUT_CAPTURE_TSTAMP_EN
            mem_ts[wr_ptr]   <= tcnt;
`endif
        end
    end

`ifdef OUT_CAPTURE_TSTAMP_EN
    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) tcnt <= '0;
        else     tcnt <= tcnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_out_capture.sv
// Directed self-checking bench for out_capture (default build; timestamp checks under OUT_CAPTURE_TSTAMP_EN).
module tb_out_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] io_out;
    logic [3:0]  out_en;
    logic [22:0] m_data;
    logic [1:0]  m_ch;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  level;
    logic        ovf;
    logic        multi;
    logic        clr_err;
`ifdef OUT_CAPTURE_TSTAMP_EN
    logic [15:0] m_tstamp;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    out_capture dut (
        .clk     (clk),
        .rst     (rst),
        .io_out  (io_out),
        .out_en  (out_en),
        .m_data  (m_data),
        .m_ch    (m_ch),
`ifdef OUT_CAPTURE_TSTAMP_EN
        .m_tstamp(m_tstamp),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .level   (level),
        .ovf     (ovf),
        .multi   (multi),
        .clr_err (clr_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [22:0] d;
        logic [1:0]  c;
    } ent_t;

    initial begin
        ent_t q[$];
        ent_t e;
        int   pushed;
        int   popped;
        logic do_pop;

        rst = 1'b1; io_out = '0; out_en = '0; m_ready = 1'b0; clr_err = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data",  32'(m_data), 32'd0);
        chk("rst_ch",    32'(m_ch), 32'd0);
        chk("rst_ovf",   32'(ovf), 32'd0);
        chk("rst_multi", 32'(multi), 32'd0);

        // Single strobe, consumed immediately
        out_en = 4'b0100; io_out = 23'h7FFFFF; m_ready = 1'b1;
        step();
        out_en = '0;
        chk("single_valid", 32'(m_valid), 32'd1);
        chk("single_ch",    32'(m_ch), 32'd2);
        chk("single_data",  32'(m_data), 32'h7FFFFF);
        chk("single_level", 32'(level), 32'd1);
        step();
        chk("single_level0", 32'(level), 32'd0);
        chk("single_valid0", 32'(m_valid), 32'd0);

        // Fill and overflow
        m_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            out_en = 4'b0001; io_out = 23'(i);
            step();
        end
        out_en = '0;
        chk("fill_level", 32'(level), 32'd8);
        chk("fill_ovf",   32'(ovf), 32'd1);
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", 32'(m_valid), 32'd1);
            chk("drain_data",  32'(m_data), 32'(i));
            step();
        end
        chk("drain_empty", 32'(m_valid), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
        chk("ovf_sticky",  32'(ovf), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Full with simultaneous push and pop
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            out_en = 4'b0001; io_out = 23'(100 + i);
            step();
        end
        chk("full_level", 32'(level), 32'd8);
        out_en = 4'b0001; io_out = 23'd42; m_ready = 1'b1;
        step();
        out_en = '0;
        chk("pp_level", 32'(level), 32'd8);
        chk("pp_ovf",   32'(ovf), 32'd0);
        for (int i = 1; i < 8; i++) begin
            chk("pp_data", 32'(m_data), 32'(100 + i));
            step();
        end
        chk("pp_last", 32'(m_data), 32'd42);
        step();
        chk("pp_empty", 32'(level), 32'd0);

        // Multi-bit strobe, then clear
        m_ready = 1'b0;
        out_en = 4'b1010; io_out = 23'h7FFFFB;
        step();
        out_en = '0;
        chk("multi_level", 32'(level), 32'd1);
        chk("multi_ch",    32'(m_ch), 32'd1);
        chk("multi_data",  32'(m_data), 32'h7FFFFB);
        chk("multi_flag",  32'(multi), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("multi_clr", 32'(multi), 32'd0);
        // Clear coinciding with a new multi event: event wins
        clr_err = 1'b1; out_en = 4'b0011; io_out = 23'd9;
        step();
        clr_err = 1'b0; out_en = '0;
        chk("multi_win", 32'(multi), 32'd1);
        chk("multi_lvl2", 32'(level), 32'd2);
        m_ready = 1'b1;
        step();
        chk("multi_ch2", 32'(m_ch), 32'd0);
        chk("multi_d2",  32'(m_data), 32'd9);
        step();
        chk("multi_drained", 32'(level), 32'd0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        // Wrap-around against a queue model
        pushed = 0; popped = 0;
        for (int t = 0; t < 40; t++) begin
            m_ready = (t % 3) != 0;
            if ((t % 2) == 0 && pushed < 20) begin
                e.d = 23'(300 + pushed);
                e.c = 2'(pushed % 4);
                out_en = 4'(1 << e.c); io_out = e.d;
            end else begin
                out_en = '0;
            end
            chk("wrap_valid", 32'(m_valid), 32'(q.size() != 0));
            chk("wrap_level", 32'(level), 32'(q.size()));
            if (q.size() != 0) begin
                chk("wrap_data", 32'(m_data), 32'(q[0].d));
                chk("wrap_ch",   32'(m_ch), 32'(q[0].c));
            end
            do_pop = (q.size() != 0) && m_ready;
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (out_en != '0) begin
                q.push_back(e);
                pushed++;
            end
            step();
        end
        out_en = '0; m_ready = 1'b1;
        for (int k = 0; k < 10 && q.size() != 0; k++) begin
            chk("wrap_tail", 32'(m_data), 32'(q[0].d));
            void'(q.pop_front());
            popped++;
            step();
        end
        chk("wrap_count", 32'(popped), 32'd20);
        chk("wrap_empty", 32'(m_valid), 32'd0);
        chk("wrap_noovf", 32'(ovf), 32'd0);

        // Mid-operation reset
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            out_en = 4'b0010; io_out = 23'(500 + i);
            step();
        end
        chk("mr_level5", 32'(level), 32'd5);
        rst = 1'b1; out_en = 4'b0001; io_out = 23'd1234;
        step();
        rst = 1'b0; out_en = '0;
        chk("mr_valid", 32'(m_valid), 32'd0);
        chk("mr_level", 32'(level), 32'd0);
        chk("mr_data",  32'(m_data), 32'd0);
`ifdef OUT_CAPTURE_TSTAMP_EN
        step(); step(); step();
`endif
        out_en = 4'b1000; io_out = 23'd77;
        step();
        out_en = '0;
        chk("post_valid", 32'(m_valid), 32'd1);
        chk("post_data",  32'(m_data), 32'd77);
        chk("post_ch",    32'(m_ch), 32'd3);
        chk("post_level", 32'(level), 32'd1);
`ifdef OUT_CAPTURE_TSTAMP_EN
        chk("post_tstamp", 32'(m_tstamp), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
